// File: rtl/fp_loader.sv
// Front-panel loader: streams program bytes into SAP-1 RAM through fp_prog/fp_write/fp_adr/fp_data, then pulses fp_clear.
// Optional build macro FP_LOADER_CHECKSUM_EN adds a csum output (mod-256 sum of bytes written in the current load).
module fp_loader #(
    parameter int unsigned ADR_W     = 4,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WR_CYC    = 8,
    parameter int unsigned CLR_CYC   = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             start,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             fp_prog,
    output logic             fp_write,
    output logic [ADR_W-1:0] fp_adr,
    output logic [7:0]       fp_data,
    output logic             fp_clear,
    output logic             busy,
    output logic             done,
    output logic [ADR_W:0]   count
`ifdef FP_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]       csum
`endif
);

    localparam int unsigned TMR_MAX_A = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
    localparam int unsigned TMR_MAX   = (TMR_MAX_A > CLR_CYC) ? TMR_MAX_A : CLR_CYC;
    localparam int unsigned TMR_W     = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
    localparam int unsigned CNT_W     = ADR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTER,
        S_WAIT,
        S_SETUP,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t             r_state, w_state;
    logic [ADR_W-1:0]   r_adr, w_adr;
    logic               r_last, w_last;
    logic [TMR_W-1:0]   r_tmr, w_tmr;
    logic               r_s_ready, w_s_ready;
    logic               r_fp_prog, w_fp_prog;
    logic               r_fp_write, w_fp_write;
    logic [ADR_W-1:0]   r_fp_adr, w_fp_adr;
    logic [7:0]         r_fp_data, w_fp_data;
    logic               r_fp_clear, w_fp_clear;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic [CNT_W-1:0]   r_count, w_count;
    logic               w_hs;
`ifdef FP_LOADER_CHECKSUM_EN
    logic [7:0]         r_csum, w_csum;
`endif

    // State and output registers; reset drops every strobe in the same cycle.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_adr      <= '0;
            r_last     <= 1'b0;
            r_tmr      <= '0;
            r_s_ready  <= 1'b0;
            r_fp_prog  <= 1'b0;
            r_fp_write <= 1'b0;
            r_fp_adr   <= '0;
            r_fp_data  <= '0;
            r_fp_clear <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
`ifdef FP_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_adr      <= w_adr;
            r_last     <= w_last;
            r_tmr      <= w_tmr;
            r_s_ready  <= w_s_ready;
            r_fp_prog  <= w_fp_prog;
            r_fp_write <= w_fp_write;
            r_fp_adr   <= w_fp_adr;
            r_fp_data  <= w_fp_data;
            r_fp_clear <= w_fp_clear;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_count    <= w_count;
`ifdef FP_LOADER_CHECKSUM_EN
            r_csum     <= w_csum;
`endif
        end
    end

    assign w_hs = s_valid && r_s_ready && (r_state == S_WAIT);

    // Next state and next register values; outputs follow the state being entered.
    always_comb begin
        w_state    = r_state;
        w_adr      = r_adr;
        w_last     = r_last;
        w_tmr      = r_tmr;
        w_fp_prog  = r_fp_prog;
        w_fp_write = r_fp_write;
        w_fp_adr   = r_fp_adr;
        w_fp_data  = r_fp_data;
        w_fp_clear = r_fp_clear;
        w_done     = 1'b0;
        w_count    = r_count;
`ifdef FP_LOADER_CHECKSUM_EN
        w_csum     = r_csum;
`endif

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state   = S_ENTER;
                    w_adr     = '0;
                    w_count   = '0;
                    w_fp_prog = 1'b1;
`ifdef FP_LOADER_CHECKSUM_EN
                    w_csum    = '0;
`endif
                end
            end
            S_ENTER: begin
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_hs) begin
                    w_fp_data = s_data;
                    w_fp_adr  = r_adr;
                    // The top word always ends the load so the address never wraps.
                    w_last    = s_last || (r_adr == {ADR_W{1'b1}});
                    w_tmr     = TMR_W'(SETUP_CYC - 1);
                    w_state   = S_SETUP;
`ifdef FP_LOADER_CHECKSUM_EN
                    w_csum    = r_csum + s_data;
`endif
                end
            end
            S_SETUP: begin
                if (r_tmr == '0) begin
                    w_state    = S_WRITE;
                    w_fp_write = 1'b1;
                    w_tmr      = TMR_W'(WR_CYC - 1);
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            S_WRITE: begin
                if (r_tmr == '0) begin
                    w_fp_write = 1'b0;
                    w_count    = r_count + CNT_W'(1);
                    if (r_last) begin
                        w_state    = S_CLEAR;
                        w_fp_prog  = 1'b0;
                        w_fp_clear = 1'b1;
                        w_tmr      = TMR_W'(CLR_CYC - 1);
                    end else begin
                        w_adr   = r_adr + ADR_W'(1);
                        w_state = S_WAIT;
                    end
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            S_CLEAR: begin
                if (r_tmr == '0) begin
                    w_fp_clear = 1'b0;
                    w_done     = 1'b1;
                    w_state    = S_DONE;
                end else begin
                    w_tmr = r_tmr - 1'b1;
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_s_ready = (w_state == S_WAIT);
        w_busy    = (w_state != S_IDLE);
    end

    assign s_ready  = r_s_ready;
    assign fp_prog  = r_fp_prog;
    assign fp_write = r_fp_write;
    assign fp_adr   = r_fp_adr;
    assign fp_data  = r_fp_data;
    assign fp_clear = r_fp_clear;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
`ifdef FP_LOADER_CHECKSUM_EN
    assign csum     = r_csum;
`endif

endmodule

// File: tb/tb_fp_loader.sv
// Randomized self-checking bench for fp_loader against a byte-stream/RAM-level reference model.
module tb_fp_loader;

    localparam int unsigned ADR_W     = 4;
    localparam int unsigned DEPTH     = 1 << ADR_W;
    localparam int unsigned SETUP_CYC = 2;
    localparam int unsigned WR_CYC    = 8;
    localparam int unsigned CLR_CYC   = 8;

    logic             sysclk = 1'b0;
    logic             reset;
    logic             start;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_last;
    logic             s_ready;
    logic             fp_prog;
    logic             fp_write;
    logic [ADR_W-1:0] fp_adr;
    logic [7:0]       fp_data;
    logic             fp_clear;
    logic             busy;
    logic             done;
    logic [ADR_W:0]   count;
`ifdef FP_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    fp_loader #(
        .ADR_W(ADR_W), .SETUP_CYC(SETUP_CYC), .WR_CYC(WR_CYC), .CLR_CYC(CLR_CYC)
    ) dut (
        .sysclk(sysclk), .reset(reset), .start(start),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .fp_prog(fp_prog), .fp_write(fp_write), .fp_adr(fp_adr), .fp_data(fp_data),
        .fp_clear(fp_clear), .busy(busy), .done(done), .count(count)
`ifdef FP_LOADER_CHECKSUM_EN
        , .csum(csum)
`endif
    );

    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_data [32];
    bit         tx_last [32];
    int         n_tx;
    logic [7:0] obs_ram [DEPTH];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {9'b0, s_ready, fp_prog, fp_write, fp_adr, fp_data, fp_clear, busy, done, count};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic fill_rand(input int n, input int last_at);
        n_tx = n;
        for (int i = 0; i < n; i++) begin
            tx_data[i] = 8'($urandom);
            tx_last[i] = (i == last_at);
        end
    endtask

    // One load: drives the stream, watches the front panel, and compares against the byte-level model.
    task automatic run_load(input int stall_at, input int mid_at, input int rst_at);
        int exp_n = 0;
        logic [7:0] exp_sum = 8'h00;
        int idx = 0, n_wr = 0, hs_cyc = -100, wr_hi = 0, clr_hi = 0, n_clr = 0, n_done = 0;
        int done_cyc = -1, same_run = 1, stall_cnt = 0, stall_bad = 0, wr_unstable = 0, quiet_bad = 0;
        bit hs, prev_wr = 1'b0, prev_clr = 1'b0, ready_seen = 1'b0, mid_done = 1'b0, finished = 1'b0;
        logic [ADR_W-1:0] prev_adr, rise_adr;
        logic [7:0] prev_data, rise_data;

        for (int i = 0; i < n_tx; i++) begin
            exp_n++;
            exp_sum = exp_sum + tx_data[i];
            if (tx_last[i] || exp_n == int'(DEPTH)) break;
        end
        for (int k = 0; k < int'(DEPTH); k++) obs_ram[k] = 8'hxx;
        prev_adr  = fp_adr;
        prev_data = fp_data;
        rise_adr  = '0;
        rise_data = '0;

        start = 1'b1;
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            hs = s_valid && s_ready;
            @(posedge sysclk);
            #1;
            start = 1'b0;
            if (hs) begin
                idx++;
                hs_cyc = cyc - 1;
            end

            if (reset) begin
                reset   = 1'b0;
                s_valid = 1'b0;
                chk_eq("rst_mid_outs", out_vec(), 32'h0);
                for (int j = 0; j < 20; j++) begin
                    @(posedge sysclk);
                    #1;
                    if (fp_clear || fp_write || fp_prog || busy || s_ready) quiet_bad++;
                end
                chk_eq("rst_mid_quiet", quiet_bad, 0);
                return;
            end

            if (cyc == 1) begin
                chk_eq("enter_busy", busy, 1);
                chk_eq("enter_prog", fp_prog, 1);
                chk_eq("enter_rdy", s_ready, 0);
                chk_eq("enter_count", count, 0);
`ifdef FP_LOADER_CHECKSUM_EN
                chk_eq("enter_csum", csum, 0);
`endif
            end
            if (s_ready && !ready_seen) begin
                ready_seen = 1'b1;
                chk_eq("start_to_rdy", cyc, 2);
            end

            if (fp_adr == prev_adr && fp_data == prev_data) same_run++;
            else same_run = 1;
            prev_adr  = fp_adr;
            prev_data = fp_data;

            if (fp_write && !prev_wr) begin
                chk_eq("wr_lat", cyc - hs_cyc, SETUP_CYC + 1);
                if (n_wr < exp_n) begin
                    chk_eq("wr_adr", fp_adr, n_wr);
                    chk_eq("wr_data", fp_data, tx_data[n_wr]);
                end else begin
                    chk_eq("wr_extra", n_wr + 1, exp_n);
                end
                chk_eq("wr_setup", same_run > int'(SETUP_CYC), 1);
                chk_eq("wr_prog", fp_prog, 1);
                obs_ram[fp_adr] = fp_data;
                rise_adr    = fp_adr;
                rise_data   = fp_data;
                wr_hi       = 0;
                wr_unstable = 0;
                n_wr++;
            end
            if (fp_write) begin
                wr_hi++;
                if (fp_adr != rise_adr || fp_data != rise_data) wr_unstable++;
            end
            if (!fp_write && prev_wr) begin
                chk_eq("wr_len", wr_hi, WR_CYC);
                chk_eq("wr_hold", {fp_adr, fp_data}, {rise_adr, rise_data});
                chk_eq("wr_stable", wr_unstable, 0);
            end
            prev_wr = fp_write;

            if (mid_at >= 0 && !mid_done && n_wr == mid_at && fp_write) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
            if (rst_at >= 0 && fp_write && int'(fp_adr) == rst_at && wr_hi == 3) reset = 1'b1;

            if (fp_clear && !prev_clr) begin
                chk_eq("clr_prog", fp_prog, 0);
                chk_eq("clr_after_wr", n_wr, exp_n);
                clr_hi = 0;
            end
            if (fp_clear) clr_hi++;
            if (!fp_clear && prev_clr) begin
                chk_eq("clr_len", clr_hi, CLR_CYC);
                n_clr++;
            end
            prev_clr = fp_clear;

            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                chk_eq("done_count", count, exp_n);
                chk_eq("done_clr", n_clr, 1);
`ifdef FP_LOADER_CHECKSUM_EN
                chk_eq("done_csum", csum, exp_sum);
`endif
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) begin
                chk_eq("idle_busy", busy, 0);
                chk_eq("idle_prog", fp_prog, 0);
            end
            if (done_cyc > 0 && cyc == done_cyc + 8) finished = 1'b1;

            if (stall_at >= 0 && idx == stall_at && stall_cnt < 20) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
                if (s_ready) begin
                    stall_cnt++;
                    if (fp_write || !fp_prog) stall_bad++;
                    if (stall_cnt == 20) chk_eq("stall_quiet", stall_bad, 0);
                end
            end else if (idx < n_tx && $urandom_range(0, 3) != 0) begin
                s_valid = 1'b1;
                s_data  = tx_data[idx];
                s_last  = tx_last[idx];
            end else begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end
        end

        s_valid = 1'b0;
        chk_eq("finished", finished, 1);
        chk_eq("done_pulses", n_done, 1);
        chk_eq("accepted", idx, exp_n);
        chk_eq("final_count", count, exp_n);
        for (int i = 0; i < exp_n; i++) chk_eq("ram", obs_ram[i], tx_data[i]);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        idle(3);
        chk_eq("rst_outs", out_vec(), 32'h0);
`ifdef FP_LOADER_CHECKSUM_EN
        chk_eq("rst_csum", csum, 0);
`endif
        reset = 1'b0;

        // Bytes offered while idle must be ignored.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        s_last  = 1'b1;
        idle(5);
        chk_eq("idle_valid", out_vec(), 32'h0);
        s_valid = 1'b0;

        n_tx = 3;
        tx_data[0] = 8'h1E; tx_last[0] = 1'b0;
        tx_data[1] = 8'h2F; tx_last[1] = 1'b0;
        tx_data[2] = 8'hF0; tx_last[2] = 1'b1;
        run_load(-1, -1, -1);
        idle(3);

        fill_rand(17, -1);
        run_load(-1, -1, -1);
        idle(3);

        fill_rand(5, 4);
        run_load(2, -1, -1);
        idle(3);

        fill_rand(10, -1);
        run_load(-1, -1, 5);
        idle(2);

        fill_rand(4, 3);
        run_load(-1, -1, -1);
        idle(2);

        fill_rand(6, 5);
        run_load(-1, 2, -1);
        idle(2);

        fill_rand(1, 0);
        run_load(-1, -1, -1);
        idle(2);

        n_tx = 3;
        tx_data[0] = 8'h80; tx_last[0] = 1'b0;
        tx_data[1] = 8'h90; tx_last[1] = 1'b0;
        tx_data[2] = 8'h05; tx_last[2] = 1'b1;
        run_load(-1, -1, -1);
`ifdef FP_LOADER_CHECKSUM_EN
        idle(4);
        chk_eq("csum_hold", csum, 8'h15);
`endif
        idle(2);

        for (int r = 0; r < 6; r++) begin
            int n;
            int la;
            n  = int'($urandom_range(1, 20));
            la = int'($urandom_range(0, n));
            fill_rand(n, (la == n) ? -1 : la);
            run_load(-1, -1, -1);
            idle(int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
